issue_queue: RTL and testbench

Dual-ported in-order instruction FIFO between decode and dispatch. Accepts up to two decoded instructions per cycle from decode and always presents the two oldest entries to dispatch as 107-bit packets. It retires 0, 1 or 2 entries per cycle according to the `issue_enable` code returned by dispatch. A pipeline flush empties it in one cycle.

---
 rtl/iq_if.sv | 28 ++
 rtl/issue_queue.sv | 98 +++++++++
 tb/tb_issue_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/iq_if.sv
// Decode/dispatch handshake bundle for issue_queue.
// The master side is decode plus dispatch; the slave side is the queue itself.
interface iq_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PW    = 106
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [1:0]    in_valid;
    logic [PW-1:0] inst0_in;
    logic [PW-1:0] inst1_in;
    logic          iq_allin;
    logic [PW:0]   inst0_to_dispatch;
    logic [PW:0]   inst1_to_dispatch;
    logic [1:0]    issue_enable;
    logic [CW-1:0] iq_count;
    logic          iq_empty;

    modport master (
        output in_valid, inst0_in, inst1_in, issue_enable,
        input  iq_allin, inst0_to_dispatch, inst1_to_dispatch, iq_count, iq_empty
    );

    modport slave (
        input  in_valid, inst0_in, inst1_in, issue_enable,
        output iq_allin, inst0_to_dispatch, inst1_to_dispatch, iq_count, iq_empty
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-ported in-order instruction FIFO between decode and dispatch.
// Accepts up to two entries per cycle, retires 0-2, presents the two oldest with a busy bit.
module issue_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PW    = 106
) (
    input  logic clk,
    input  logic rst_,
    input  logic flush,
    iq_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PW-1:0] mem [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW-1:0] head_p1, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic          allin;
    logic [1:0]    push, pop_req, pop;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    // Conservative: derived from registered count, ignores any same-cycle pop.
    assign allin = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        push = 2'd0;
        if (allin) begin
            case (bus.in_valid)
                2'b01:   push = 2'd1;
                2'b11:   push = 2'd2;
                default: push = 2'd0;
            endcase
        end

        case (bus.issue_enable)
            2'b01:   pop_req = 2'd1;
            2'b10:   pop_req = 2'd2;
            default: pop_req = 2'd0;
        endcase

        // Clamp to occupancy so the queue never underflows.
        pop = pop_req;
        if (count_q < CW'(pop_req)) begin
            pop = count_q[1:0];
        end

        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset or cleared on flush; the busy gating hides stale entries.
    always_ff @(posedge clk) begin
        if (!flush && push != 2'd0) begin
            mem[tail_q] <= bus.inst0_in;
            if (push == 2'd2) begin
                mem[tail_p1] <= bus.inst1_in;
            end
        end
    end

    always_comb begin
        bus.inst0_to_dispatch = '0;
        bus.inst1_to_dispatch = '0;
        if (count_q >= CW'(1)) begin
            bus.inst0_to_dispatch = {mem[head_q], 1'b1};
        end
        if (count_q >= CW'(2)) begin
            bus.inst1_to_dispatch = {mem[head_p1], 1'b1};
        end
    end

    assign bus.iq_allin = allin;
    assign bus.iq_count = count_q;
    assign bus.iq_empty = (count_q == '0);

endmodule

// File: tb/tb_issue_queue.sv
// Directed table-driven bench for issue_queue plus hand-written reset/latency sequences.
module tb_issue_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 106;

    typedef struct {
        logic        flush;
        logic [1:0]  iv;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [1:0]  ie;
        int          cnt;
        logic        allin;
        logic        b0;
        logic [31:0] e0;
        logic        b1;
        logic [31:0] e1;
        string       name;
    } vec_t;

    logic clk;
    logic rst_;
    logic flush;

    iq_if #(.DEPTH(DEPTH), .PW(PW)) bus ();

    issue_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        logic [9:0] low;
        low = pc[9:0];
        return {pc, ~pc, pc ^ 32'h5a5a_0f0f, low};
    endfunction

    function automatic logic [PW:0] pkt(input logic b, input logic [31:0] pc);
        if (!b) return '0;
        return {mk(pc), 1'b1};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input int cnt, input logic allin,
                                 input logic b0, input logic [31:0] e0,
                                 input logic b1, input logic [31:0] e1);
        check({name, " count"}, 128'(bus.iq_count), 128'(cnt));
        check({name, " allin"}, 128'(bus.iq_allin), 128'(allin));
        check({name, " empty"}, 128'(bus.iq_empty), 128'(cnt == 0));
        check({name, " inst0"}, 128'(bus.inst0_to_dispatch), 128'(pkt(b0, e0)));
        check({name, " inst1"}, 128'(bus.inst1_to_dispatch), 128'(pkt(b1, e1)));
    endtask

    task automatic add(input string name, input logic fl, input logic [1:0] iv,
                       input logic [31:0] pa, input logic [31:0] pb, input logic [1:0] ie,
                       input int cnt, input logic allin, input logic b0, input logic [31:0] e0,
                       input logic b1, input logic [31:0] e1);
        vec_t v;
        v.name = name; v.flush = fl; v.iv = iv; v.pa = pa; v.pb = pb; v.ie = ie;
        v.cnt = cnt; v.allin = allin; v.b0 = b0; v.e0 = e0; v.b1 = b1; v.e1 = e1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic [1:0] iv, input logic [31:0] pa,
                         input logic [31:0] pb, input logic [1:0] ie);
        flush            = fl;
        bus.in_valid     = iv;
        bus.inst0_in     = mk(pa);
        bus.inst1_in     = mk(pb);
        bus.issue_enable = ie;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_     = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);

        // Basic push/pop and illegal codes
        add("dual_push", 0, 2'b11, 32'h100, 32'h104, 2'b00, 2, 1, 1, 32'h100, 1, 32'h104);
        add("single_push", 0, 2'b01, 32'h108, 32'h0, 2'b00, 3, 1, 1, 32'h100, 1, 32'h104);
        add("pop1", 0, 2'b00, 32'h0, 32'h0, 2'b01, 2, 1, 1, 32'h104, 1, 32'h108);
        add("iv10_nowrite", 0, 2'b10, 32'h999, 32'h99c, 2'b00, 2, 1, 1, 32'h104, 1, 32'h108);
        add("ie11_nopop", 0, 2'b00, 32'h0, 32'h0, 2'b11, 2, 1, 1, 32'h104, 1, 32'h108);
        add("pop2_empty", 0, 2'b00, 32'h0, 32'h0, 2'b10, 0, 1, 0, 32'h0, 0, 32'h0);
        // Fill to 15
        for (int k = 0; k < 7; k++) begin
            add($sformatf("fill%0d", k), 0, 2'b11, 32'h200 + 32'(8 * k), 32'h204 + 32'(8 * k),
                2'b00, 2 * k + 2, 1, 1, 32'h200, 1, 32'h204);
        end
        add("fill_last", 0, 2'b01, 32'h238, 32'h0, 2'b00, 15, 0, 1, 32'h200, 1, 32'h204);
        add("full_drop", 0, 2'b11, 32'h300, 32'h304, 2'b00, 15, 0, 1, 32'h200, 1, 32'h204);
        add("full_pop2", 0, 2'b00, 32'h0, 32'h0, 2'b10, 13, 1, 1, 32'h208, 1, 32'h20c);
        add("flush_prio", 1, 2'b11, 32'h800, 32'h804, 2'b01, 0, 1, 0, 32'h0, 0, 32'h0);
        // Move head/tail to 14 then wrap
        for (int k = 0; k < 7; k++) begin
            add($sformatf("wfill%0d", k), 0, 2'b11, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k),
                2'b00, 2 * k + 2, 1, 1, 32'h500, 1, 32'h504);
        end
        for (int j = 1; j <= 7; j++) begin
            add($sformatf("wdrain%0d", j), 0, 2'b00, 32'h0, 32'h0, 2'b10, 14 - 2 * j, 1,
                j < 7, (j < 7) ? 32'h500 + 32'(8 * j) : 32'h0,
                j < 7, (j < 7) ? 32'h504 + 32'(8 * j) : 32'h0);
        end
        add("at14_push", 0, 2'b11, 32'h400, 32'h404, 2'b00, 2, 1, 1, 32'h400, 1, 32'h404);
        add("wrap_pushpop", 0, 2'b11, 32'h408, 32'h40c, 2'b10, 2, 1, 1, 32'h408, 1, 32'h40c);
        add("wrap_pop1", 0, 2'b00, 32'h0, 32'h0, 2'b01, 1, 1, 1, 32'h40c, 0, 32'h0);
        add("overpop", 0, 2'b00, 32'h0, 32'h0, 2'b10, 0, 1, 0, 32'h0, 0, 32'h0);
        add("after_overpop", 0, 2'b01, 32'h600, 32'h0, 2'b11, 1, 1, 1, 32'h600, 0, 32'h0);
        add("iv10_again", 0, 2'b10, 32'h999, 32'h0, 2'b00, 1, 1, 1, 32'h600, 0, 32'h0);
        add("push2_clamp", 0, 2'b11, 32'h610, 32'h614, 2'b10, 2, 1, 1, 32'h610, 1, 32'h614);

        // Reset state, sampled while reset is held
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset", 0, 1, 0, 32'h0, 0, 32'h0);
        rst_ = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].pa, vecs[i].pb, vecs[i].ie);
            @(posedge clk);
            #1;
            check_outputs(vecs[i].name, vecs[i].cnt, vecs[i].allin,
                          vecs[i].b0, vecs[i].e0, vecs[i].b1, vecs[i].e1);
        end

        // No same-cycle bypass: a pending push must not be visible before the edge
        drive(1'b0, 2'b11, 32'h700, 32'h704, 2'b00);
        #2;
        check("no_bypass count", 128'(bus.iq_count), 128'(2));
        check("no_bypass inst0", 128'(bus.inst0_to_dispatch), 128'(pkt(1, 32'h610)));
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        check_outputs("latency", 4, 1, 1, 32'h610, 1, 32'h614);

        // Asynchronous reset mid-operation, checked before any clock edge
        #2;
        rst_ = 1'b0;
        #1;
        check_outputs("async_reset", 0, 1, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        drive(1'b0, 2'b01, 32'h720, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
        check_outputs("post_reset_push", 1, 1, 1, 32'h720, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
